// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection controller front end.
//   LED_N_GREEN           : light FSM ledOut code for "north green"
//   GO_SENSOR / GO_EMERG  : bit positions inside go_control
//   sensor_state_t        : car-sensor request state
//   emerg_state_t         : emergency request state
package intersection_pkg;

    localparam logic [2:0] LED_N_GREEN = 3'b000;

    localparam int GO_SENSOR = 0;
    localparam int GO_EMERG  = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } sensor_state_t;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_ARMED = 2'd1,
        E_CYCLE = 2'd2
    } emerg_state_t;

endpackage

// File: rtl/go_request_debounce.sv
// Synchroniser plus debouncer for one asynchronous, bouncing input.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   raw    : asynchronous input
//   clean  : registered level, changes only after DEBOUNCE_CYCLES
//            consecutive synced samples differ from the current level
module debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic clean
);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;

    // Counter counts consecutive mismatching samples; any agreeing sample
    // (including a one-cycle glitch back) restarts it from zero.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/go_request.sv
// Request conditioner in front of the intersection light FSM.
//   clk, resetn   : system clock, asynchronous active-low reset
//   sensor_raw    : car detector (async, bouncing)
//   emerg_raw     : emergency button (async, bouncing)
//   led_state     : light FSM ledOut code, 3'b000 = north green
//   go_control    : [0] sensor request, [1] emergency request (registered)
//   sensor_clean  : debounced sensor level (registered)
//   emerg_clean   : debounced emergency level (registered)
module go_request
    import intersection_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sensor_raw,
    input  logic       emerg_raw,
    input  logic [2:0] led_state,
    output logic [1:0] go_control,
    output logic       sensor_clean,
    output logic       emerg_clean
);

    logic          sensor_clean_w;
    logic          emerg_clean_w;
    logic          sensor_prev_q;
    logic          emerg_prev_q;
    logic [2:0]    led_prev_q;
    sensor_state_t s_state_q;
    sensor_state_t s_state_d;
    emerg_state_t  e_state_q;
    emerg_state_t  e_state_d;
    logic [1:0]    go_q;
    logic [1:0]    go_d;

    logic sensor_rise;
    logic emerg_rise;
    logic leave;
    logic ret;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_sensor_db (
        .clk   (clk),
        .resetn(resetn),
        .raw   (sensor_raw),
        .clean (sensor_clean_w)
    );

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_emerg_db (
        .clk   (clk),
        .resetn(resetn),
        .raw   (emerg_raw),
        .clean (emerg_clean_w)
    );

    assign sensor_rise = sensor_clean_w & ~sensor_prev_q;
    assign emerg_rise  = emerg_clean_w & ~emerg_prev_q;

    // Leaving / returning to north green marks the start / end of service.
    assign leave = (led_prev_q == LED_N_GREEN) && (led_state != LED_N_GREEN);
    assign ret   = (led_prev_q != LED_N_GREEN) && (led_state == LED_N_GREEN);

    always_comb begin
        s_state_d = s_state_q;
        case (s_state_q)
            S_IDLE:  if (sensor_rise)     s_state_d = S_PEND;
            // A sensor drop while pending does not withdraw the request.
            S_PEND:  if (leave)           s_state_d = S_HOLD;
            // Wait for the car to leave so a parked car requests only once.
            S_HOLD:  if (!sensor_clean_w) s_state_d = S_IDLE;
            default:                      s_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        e_state_d = e_state_q;
        case (e_state_q)
            E_IDLE:  if (emerg_rise) e_state_d = E_ARMED;
            E_ARMED: if (leave)      e_state_d = E_CYCLE;
            E_CYCLE: if (ret)        e_state_d = E_IDLE;
            default:                 e_state_d = E_IDLE;
        endcase
    end

    // Outputs are decoded from next state so they register together with it.
    always_comb begin
        go_d            = 2'b00;
        go_d[GO_SENSOR] = (s_state_d == S_PEND);
        go_d[GO_EMERG]  = (e_state_d == E_ARMED) || (e_state_d == E_CYCLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sensor_prev_q <= 1'b0;
            emerg_prev_q  <= 1'b0;
            led_prev_q    <= LED_N_GREEN;
            s_state_q     <= S_IDLE;
            e_state_q     <= E_IDLE;
            go_q          <= 2'b00;
        end else begin
            sensor_prev_q <= sensor_clean_w;
            emerg_prev_q  <= emerg_clean_w;
            led_prev_q    <= led_state;
            s_state_q     <= s_state_d;
            e_state_q     <= e_state_d;
            go_q          <= go_d;
        end
    end

    assign go_control   = go_q;
    assign sensor_clean = sensor_clean_w;
    assign emerg_clean  = emerg_clean_w;

endmodule

// File: tb/tb_go_request.sv
// Bench for go_request with DEBOUNCE_CYCLES = 4: directed scenarios followed
// by random stimulus, all outputs compared every cycle against a reference
// model plus a few absolute spot checks.
module tb_go_request;

    localparam int DB = 4;

    logic       clk;
    logic       resetn;
    logic       sensor_raw;
    logic       emerg_raw;
    logic [2:0] led_state;
    logic [1:0] go_control;
    logic       sensor_clean;
    logic       emerg_clean;

    logic [3:0] dut_out;
    assign dut_out = {go_control, sensor_clean, emerg_clean};

    go_request #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sensor_raw  (sensor_raw),
        .emerg_raw   (emerg_raw),
        .led_state   (led_state),
        .go_control  (go_control),
        .sensor_clean(sensor_clean),
        .emerg_clean (emerg_clean)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       probe = 1'b0;
    logic [3:0] probe_exp;
    string      probe_name;

    // ---------------- reference model ----------------
    // Raw samples per edge; clean flips once the last DB synchronised
    // samples (two edges old) all disagree with it.
    bit         s_hist[$];
    bit         e_hist[$];
    bit         m_sclean, m_eclean;
    bit         m_srose, m_erose;
    bit         m_spend, m_sserved;
    bit         m_earmed, m_ecycle;
    logic [2:0] m_led_prev;

    function automatic bit flip_due(input bit h[$], input bit cur);
        int n = h.size();
        for (int i = 0; i < DB; i++) begin
            if (h[n-3-i] == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        s_hist = {};
        e_hist = {};
        for (int i = 0; i < DB + 2; i++) begin
            s_hist.push_back(1'b0);
            e_hist.push_back(1'b0);
        end
        m_sclean = 0; m_eclean = 0; m_srose = 0; m_erose = 0;
        m_spend = 0; m_sserved = 0; m_earmed = 0; m_ecycle = 0;
        m_led_prev = 3'b000;
    endtask

    task automatic model_step();
        bit leave, ret, s_flip, e_flip;
        leave = (m_led_prev == 3'b000) && (led_state != 3'b000);
        ret   = (m_led_prev != 3'b000) && (led_state == 3'b000);
        // sensor request: one request per arrival, dropped once served
        if (m_spend) begin
            if (leave) begin m_spend = 0; m_sserved = 1; end
        end else if (m_sserved) begin
            if (!m_sclean) m_sserved = 0;
        end else if (m_srose) begin
            m_spend = 1;
        end
        // emergency request: held from press through a full light cycle
        if (m_earmed) begin
            if (leave) begin m_earmed = 0; m_ecycle = 1; end
        end else if (m_ecycle) begin
            if (ret) m_ecycle = 0;
        end else if (m_erose) begin
            m_earmed = 1;
        end
        m_led_prev = led_state;
        s_hist.push_back(sensor_raw);
        e_hist.push_back(emerg_raw);
        s_flip = flip_due(s_hist, m_sclean);
        e_flip = flip_due(e_hist, m_eclean);
        m_srose = s_flip && !m_sclean;
        m_erose = e_flip && !m_eclean;
        if (s_flip) m_sclean = !m_sclean;
        if (e_flip) m_eclean = !m_eclean;
        while (s_hist.size() > DB + 4) void'(s_hist.pop_front());
        while (e_hist.size() > DB + 4) void'(e_hist.pop_front());
        exp_q.push_back({m_earmed | m_ecycle, m_spend, m_sclean, m_eclean});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                model_reset();
                if (clk) exp_q.push_back(4'b0000);
            end else begin
                model_step();
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [3:0] exp;
        forever begin
            @(negedge clk or posedge probe);
            if (probe) begin
                checks++;
                if (dut_out !== probe_exp) begin
                    errors++;
                    $display("FAIL %s got go/sc/ec=%b want %b at %0t",
                             probe_name, dut_out, probe_exp, $time);
                end
            end else if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if (dut_out !== exp) begin
                    errors++;
                    $display("FAIL cycle_out got go/sc/ec=%b want %b at %0t",
                             dut_out, exp, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic spot(input logic [3:0] exp, input string name);
        probe_exp  = exp;
        probe_name = name;
        probe = 1'b1;
        #1;
        probe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog bench did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn = 1'b0; sensor_raw = 1'b1; emerg_raw = 1'b1; led_state = 3'b000;
        tick(3);
        sensor_raw = 1'b0; emerg_raw = 1'b0; resetn = 1'b1;
        tick(20);
        spot(4'b0000, "reset_idle");

        // bounce: period-4 toggling never settles, then hold high
        for (int i = 0; i < 20; i++) begin
            sensor_raw = ((i / 2) % 2) == 0;
            tick(1);
        end
        sensor_raw = 1'b1;
        tick(6);
        spot(4'b0010, "bounce_clean_edge6");
        tick(1);
        spot(4'b0110, "bounce_go_edge7");

        // sensor service, parked car, re-arm
        led_state = 3'b001; tick(1);
        spot(4'b0010, "sensor_served");
        led_state = 3'b000; tick(5);
        spot(4'b0010, "parked_no_rerequest");
        sensor_raw = 1'b0; tick(10);
        sensor_raw = 1'b1; tick(7);
        spot(4'b0110, "sensor_rearm");
        led_state = 3'b001; tick(1);
        led_state = 3'b000; tick(2);
        sensor_raw = 1'b0; tick(8);

        // emergency full cycle with an ignored second press
        emerg_raw = 1'b1; tick(7);
        spot(4'b1001, "emerg_armed");
        emerg_raw = 1'b0; tick(8);
        led_state = 3'b001; tick(3);
        led_state = 3'b010; emerg_raw = 1'b1; tick(8);
        led_state = 3'b111; emerg_raw = 1'b0; tick(8);
        spot(4'b1000, "emerg_cycle_hold");
        led_state = 3'b000; tick(1);
        spot(4'b0000, "emerg_ret_clear");

        // simultaneous requests
        sensor_raw = 1'b1; emerg_raw = 1'b1; tick(7);
        spot(4'b1111, "both_requests");
        led_state = 3'b001; tick(1);
        spot(4'b1011, "both_leave");
        led_state = 3'b000; tick(1);
        sensor_raw = 1'b0; emerg_raw = 1'b0; tick(8);
        sensor_raw = 1'b1; emerg_raw = 1'b1; tick(7);
        spot(4'b1111, "both_again");

        // asynchronous reset between edges
        emerg_raw = 1'b0;
        resetn = 1'b0;
        spot(4'b0000, "async_reset");
        resetn = 1'b1;
        tick(6);
        spot(4'b0010, "post_reset_clean");
        tick(1);
        spot(4'b0110, "post_reset_go");

        // random phase
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) sensor_raw = ~sensor_raw;
            if ($urandom_range(0, 3) == 0) emerg_raw = ~emerg_raw;
            if ($urandom_range(0, 2) == 0)
                led_state = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            if ($urandom_range(0, 49) == 0) begin
                resetn = 1'b0;
                #1;
                resetn = 1'b1;
            end
            tick($urandom_range(1, 8));
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
